debug_frame_tx: RTL
===================

Name: debug_frame_tx

Overview:
- Parametrised successor of the debugger transmit path.
- Snapshots an arbitrary-width debug bus (pipeline state, registers, memories) when `send` is pulsed.
- Serialises the snapshot as a framed byte stream (header, length, payload) into the UART transmitter using the tx_busy/wr_uart handshake.
- Sits between the debugger receive FSM (source of `send`) and the UART.

Parameters:
- DATA_W, 1729: width of the debug bus in bits (>=1).
- HEADER, 8'hA5: frame start byte.
- MSB_FIRST, 1: 1 = most significant payload byte sent first; 0 = least significant first.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- send  in  1  start request; sampled only in IDLE.
- send_data  in  DATA_W  debug bus to transmit.
- tx_busy  in  1  UART transmitter busy.
- wr_uart  out  1  one-cycle write strobe to the UART.
- w_data  out  8  byte presented to the UART; valid while wr_uart=1.
- busy  out  1  high from snapshot until the frame completes.
- data_sent  out  1  one-cycle pulse after the last byte is accepted.
- byte_idx  out  16  index of the current payload byte (debug visibility).

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; state IDLE; snapshot register and counters cleared.
- Reset mid-frame aborts the frame immediately. No further wr_uart; the partial frame is not resumed.
- NBYTES = ceil(DATA_W/8). The snapshot is zero-extended to NBYTES*8 bits; pad bits occupy the MSBs of the top byte.
- Frame order: HEADER, LEN_HI, LEN_LO, payload bytes 0..NBYTES-1, then an optional checksum byte.
  - LEN = NBYTES as a 16-bit value.
  - Payload byte 0 is the top byte when MSB_FIRST=1, the bottom byte when MSB_FIRST=0.
- States: IDLE, LOAD, EMIT, WAIT_ACK, WAIT_FREE, DONE.
- IDLE:
  - send=1 → LOAD. The snapshot captures send_data on this edge; busy=1 from the next cycle.
  - send while busy=1 is ignored (no queueing).
- LOAD: selects the HEADER byte; → EMIT.
- EMIT:
  - If tx_busy=0: wr_uart=1 for exactly this cycle with w_data = current byte; → WAIT_ACK.
  - Else: stay in EMIT.
- WAIT_ACK: one cycle, giving the UART time to raise tx_busy; → WAIT_FREE.
- WAIT_FREE:
  - Wait for tx_busy=0, then advance the byte pointer.
  - More bytes remain → EMIT; otherwise → DONE.
- DONE: data_sent=1 for one cycle; busy=0 on the following cycle; → IDLE.
- send_data changes after the snapshot do not affect the frame in progress.
- Latency: send to first wr_uart = 2 cycles when tx_busy=0. Between bytes, at least 3 cycles plus the UART busy time.
- byte_idx:
  - Holds 0 during the header and length bytes.
  - Counts 0..NBYTES-1 during the payload.
  - Saturates at NBYTES-1.
- The w_data mux indexes the snapshot by byte_idx; no wide shift register is required.
- tx_busy held high indefinitely: the block waits (no timeout); busy stays 1.

Optional Feature:
- DBG_CHECKSUM_EN defined:
  - A checksum byte is appended after the last payload byte.
  - Checksum = XOR of every preceding frame byte (header, LEN_HI, LEN_LO, all payload bytes).
  - The LEN field still counts payload bytes only.
  - data_sent pulses after the checksum byte completes.
- DBG_CHECKSUM_EN not defined: the frame ends after the last payload byte; no checksum logic is synthesised.

Test Plan:
- DATA_W=16, MSB_FIRST=1, send_data=16'hBEEF, UART model raising busy for 10 cycles per byte, checksum off → bytes A5 00 02 BE EF in order; exactly 5 wr_uart pulses; one data_sent pulse; busy low afterwards.
- Same as previous with DBG_CHECKSUM_EN → bytes A5 00 02 BE EF F6; data_sent only after F6.
- DATA_W=12, MSB_FIRST=0, send_data=12'hABC → bytes A5 00 02 BC 0A (zero-padded top nibble).
- Capture and ignore: DATA_W=16, change send_data to 16'h1234 and pulse send again during the frame → frame still carries BE EF; the second send is ignored; only one data_sent pulse.
- Stall: tx_busy held high 50 cycles before the first byte → wr_uart stays 0 until tx_busy falls; first wr_uart occurs in the cycle tx_busy=0 is seen in EMIT.
- Reset mid-frame: assert reset low during payload byte 1 → wr_uart, busy, data_sent and w_data are 0 immediately. A send after release produces a complete new frame starting with A5.

Source files
------------

// File: rtl/debug_frame_tx.sv
// Snapshots a wide debug bus and streams it to a UART as HEADER, LEN_HI, LEN_LO, payload.
// Define DBG_CHECKSUM_EN to append an XOR checksum byte after the payload.
module debug_frame_tx #(
  parameter int         DATA_W    = 1729,
  parameter logic [7:0] HEADER    = 8'hA5,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              send,
  input  logic [DATA_W-1:0] send_data,
  input  logic              tx_busy,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic              data_sent,
  output logic [15:0]       byte_idx
);
  localparam int NBYTES = (DATA_W + 7) / 8;
  localparam int PAD_W  = NBYTES * 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int POS_W  = 18;
`ifdef DBG_CHECKSUM_EN
  localparam int NFRAME = NBYTES + 4;
`else
  localparam int NFRAME = NBYTES + 3;
`endif
  localparam logic [15:0]      LEN      = 16'(NBYTES);
  localparam logic [POS_W-1:0] PAY_POS  = POS_W'(3);
  localparam logic [POS_W-1:0] LAST_PAY = POS_W'(NBYTES + 2);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NFRAME - 1);

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, WAIT_ACK, WAIT_FREE, DONE} state_e;

  state_e                 state_q, state_d;
  logic [NBYTES-1:0][7:0] snap_q, snap_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic [15:0]            pidx;
  logic [IDX_W-1:0]       sel;
  logic [7:0]             pay_byte, cur_byte;
`ifdef DBG_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  // pos_q walks the whole frame; the payload index is derived from it and saturates.
  always_comb begin
    pidx = 16'h0000;
    if (pos_q > LAST_PAY)
      pidx = 16'(NBYTES - 1);
    else if (pos_q >= PAY_POS)
      pidx = 16'(pos_q - PAY_POS);
  end

  assign byte_idx = pidx;
  assign sel      = MSB_FIRST ? (IDX_W'(NBYTES - 1) - IDX_W'(pidx)) : IDX_W'(pidx);
  assign pay_byte = snap_q[sel];

  always_comb begin
    cur_byte = pay_byte;
    if (pos_q == POS_W'(0))
      cur_byte = HEADER;
    else if (pos_q == POS_W'(1))
      cur_byte = LEN[15:8];
    else if (pos_q == POS_W'(2))
      cur_byte = LEN[7:0];
`ifdef DBG_CHECKSUM_EN
    else if (pos_q > LAST_PAY)
      cur_byte = csum_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    pos_d     = pos_q;
`ifdef DBG_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    wr_uart   = 1'b0;
    w_data    = 8'h00;
    data_sent = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (send) begin
          snap_d  = PAD_W'(send_data);
          state_d = LOAD;
        end
      end
      LOAD: begin
        pos_d   = '0;
`ifdef DBG_CHECKSUM_EN
        csum_d  = 8'h00;
`endif
        state_d = EMIT;
      end
      EMIT: begin
        if (!tx_busy) begin
          wr_uart = 1'b1;
          w_data  = cur_byte;
`ifdef DBG_CHECKSUM_EN
          csum_d  = csum_q ^ cur_byte;
`endif
          state_d = WAIT_ACK;
        end
      end
      // Give the UART a cycle to raise tx_busy before we look at it again.
      WAIT_ACK: state_d = WAIT_FREE;
      WAIT_FREE: begin
        if (!tx_busy) begin
          if (pos_q == LAST_POS) begin
            state_d = DONE;
          end else begin
            pos_d   = pos_q + POS_W'(1);
            state_d = EMIT;
          end
        end
      end
      DONE: begin
        data_sent = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      pos_q   <= '0;
`ifdef DBG_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      pos_q   <= pos_d;
`ifdef DBG_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule
